// File: rtl/mm_uart_tx.sv
// mm_uart_tx: memory-mapped UART transmitter (8N1) with a small TX FIFO.
//
// A bus FSM decodes accesses in a 16-byte window at BaseAddress and answers
// each held request with a single-cycle WriteOK/ReadOK. A TX FSM pulls bytes
// from the FIFO and shifts them out LSB-first on TxD at a programmable bit
// period (DIVISOR clocks per bit, 0 treated as 1).
//
// Ports:
//   Clock        - sole clock, rising edge
//   nReset       - asynchronous active-low reset
//   AddressBus   - byte address; [31:4] window decode, [3:2] register select
//   DataWriteBus - write data
//   WriteAssert  - write request, held until WriteOK
//   ReadAssert   - read request, held until ReadOK
//   DataReadBus  - registered read data, zero outside the ReadOK cycle
//   WriteOK      - one-cycle write acknowledge
//   ReadOK       - one-cycle read acknowledge
//   TxD          - serial output, idle high
//
// Register map (AddressBus[3:2]):
//   0 TXDATA  : write pushes [7:0]; reads 0
//   1 STATUS  : {16'b0, count[7:0], 4'b0, overflow, busy, empty, full};
//               write 1 to bit3 clears overflow
//   2 DIVISOR : rw [15:0]
//   3 reserved: reads 0, writes ignored
module mm_uart_tx #(
  parameter logic [31:0] BaseAddress  = 32'h0001_0000,
  parameter int          FifoDepth    = 4,
  parameter logic [15:0] ResetDivisor = 16'd868
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [31:0] AddressBus,
  input  logic [31:0] DataWriteBus,
  input  logic        WriteAssert,
  input  logic        ReadAssert,
  output logic [31:0] DataReadBus,
  output logic        WriteOK,
  output logic        ReadOK,
  output logic        TxD
);

  localparam int AW = $clog2(FifoDepth);
  localparam logic [AW:0] FULL_COUNT = FifoDepth[AW:0];

  typedef enum logic [1:0] {B_IDLE, B_ACK, B_RELEASE} bus_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  bus_state_t    bus_state;
  tx_state_t     tx_state;

  logic [7:0]    fifo_mem [FifoDepth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty;

  logic [15:0]   divisor, div_eff, div_lat, period_cnt;
  logic          overflow;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;

  logic          addr_hit, accept, wr_acc, push_req, push, pop, bit_end, busy;
  logic [1:0]    reg_sel;
  logic [7:0]    count8;
  logic [31:0]   status_word, rd_mux;
  logic          unused_bits;

  assign unused_bits = ^{AddressBus[1:0], DataWriteBus[31:16]};

  assign addr_hit = (AddressBus[31:4] == BaseAddress[31:4]);
  assign reg_sel  = AddressBus[3:2];
  // A simultaneous read and write services only the write.
  assign accept   = (bus_state == B_IDLE) && (WriteAssert || ReadAssert) && addr_hit;
  assign wr_acc   = accept && WriteAssert;
  assign push_req = wr_acc && (reg_sel == 2'd0);

  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign fifo_empty = (fifo_count == '0);

  assign div_eff = (divisor == 16'd0) ? 16'd1 : divisor;
  assign bit_end = (period_cnt <= 16'd1);
  assign busy    = (tx_state != T_IDLE);

  // Pop when starting a frame from idle or chaining straight out of a stop bit.
  assign pop  = !fifo_empty && ((tx_state == T_IDLE) || ((tx_state == T_STOP) && bit_end));
  // A full FIFO still accepts a push in the cycle it is popped.
  assign push = push_req && (!fifo_full || pop);

  assign count8      = 8'(fifo_count);
  assign status_word = {16'h0, count8, 4'h0, overflow, busy, fifo_empty, fifo_full};

  always_comb begin
    rd_mux = 32'h0;
    case (reg_sel)
      2'd1:    rd_mux = status_word;
      2'd2:    rd_mux = {16'h0, divisor};
      default: rd_mux = 32'h0;
    endcase
  end

  // Bus FSM plus the writable control registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      bus_state   <= B_IDLE;
      WriteOK     <= 1'b0;
      ReadOK      <= 1'b0;
      DataReadBus <= 32'h0;
      divisor     <= ResetDivisor;
      overflow    <= 1'b0;
    end else begin
      WriteOK     <= 1'b0;
      ReadOK      <= 1'b0;
      DataReadBus <= 32'h0;
      case (bus_state)
        B_IDLE: begin
          if (accept) begin
            bus_state <= B_ACK;
            WriteOK   <= WriteAssert;
            ReadOK    <= !WriteAssert;
            if (!WriteAssert) DataReadBus <= rd_mux;
          end
          if (wr_acc && (reg_sel == 2'd1) && DataWriteBus[3]) overflow <= 1'b0;
          if (wr_acc && (reg_sel == 2'd2)) divisor <= DataWriteBus[15:0];
          if (push_req && !push) overflow <= 1'b1;
        end
        B_ACK:     bus_state <= B_RELEASE;
        B_RELEASE: if (!WriteAssert && !ReadAssert) bus_state <= B_IDLE;
        default:   bus_state <= B_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifo_mem[wr_ptr] <= DataWriteBus[7:0];
  end

  // Shift register: loaded on pop, advanced at each data-bit boundary.
  always_ff @(posedge Clock) begin
    if (pop) shift <= fifo_mem[rd_ptr];
    else if ((tx_state == T_DATA) && bit_end) shift <= {1'b0, shift[7:1]};
  end

  // TX FSM. TxD is registered from the current state, so the line lags the
  // state by one clock; every bit still lasts exactly div_lat clocks.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      tx_state   <= T_IDLE;
      TxD        <= 1'b1;
      bit_cnt    <= 3'd0;
      period_cnt <= 16'd1;
      div_lat    <= 16'd1;
    end else begin
      case (tx_state)
        T_START: TxD <= 1'b0;
        T_DATA:  TxD <= shift[0];
        default: TxD <= 1'b1;
      endcase
      case (tx_state)
        T_IDLE: begin
          if (pop) begin
            tx_state   <= T_START;
            div_lat    <= div_eff;
            period_cnt <= div_eff;
          end
        end
        T_START: begin
          if (bit_end) begin
            tx_state   <= T_DATA;
            period_cnt <= div_lat;
            bit_cnt    <= 3'd0;
          end else period_cnt <= period_cnt - 16'd1;
        end
        T_DATA: begin
          if (bit_end) begin
            period_cnt <= div_lat;
            bit_cnt    <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) tx_state <= T_STOP;
          end else period_cnt <= period_cnt - 16'd1;
        end
        T_STOP: begin
          if (bit_end) begin
            if (pop) begin
              tx_state   <= T_START;
              div_lat    <= div_eff;
              period_cnt <= div_eff;
            end else tx_state <= T_IDLE;
          end else period_cnt <= period_cnt - 16'd1;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_uart_tx.sv
// tb_mm_uart_tx: directed self-checking bench for mm_uart_tx.
module tb_mm_uart_tx;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic [31:0] AddressBus = 32'h0;
  logic [31:0] DataWriteBus = 32'h0;
  logic        WriteAssert = 1'b0;
  logic        ReadAssert = 1'b0;
  logic [31:0] DataReadBus;
  logic        WriteOK, ReadOK, TxD;

  int checks = 0;
  int passes = 0;
  int wr_ok_cnt = 0;
  int rd_ok_cnt = 0;
  int txd_low_cnt = 0;
  int leak_cnt = 0;

  mm_uart_tx dut (
    .Clock(Clock), .nReset(nReset), .AddressBus(AddressBus),
    .DataWriteBus(DataWriteBus), .WriteAssert(WriteAssert),
    .ReadAssert(ReadAssert), .DataReadBus(DataReadBus),
    .WriteOK(WriteOK), .ReadOK(ReadOK), .TxD(TxD)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (WriteOK === 1'b1) wr_ok_cnt++;
    if (ReadOK === 1'b1) rd_ok_cnt++;
    if (TxD !== 1'b1) txd_low_cnt++;
    if (ReadOK !== 1'b1 && DataReadBus !== 32'h0) leak_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Expected TxD level k clocks after the start-bit falling edge.
  function automatic logic exp_txd(input logic [7:0] b, input int div, input int k);
    int idx;
    if (k < 0 || k >= 10 * div) return 1'b1;
    idx = k / div;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output bit ok);
    @(negedge Clock);
    AddressBus = a; DataWriteBus = d; WriteAssert = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge Clock); #1;
      if (WriteOK === 1'b1) ok = 1'b1;
    end
    WriteAssert = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output bit ok);
    @(negedge Clock);
    AddressBus = a; ReadAssert = 1'b1;
    ok = 1'b0; d = 32'h0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge Clock); #1;
      if (ReadOK === 1'b1) begin ok = 1'b1; d = DataReadBus; end
    end
    ReadAssert = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; bit ok; int r0, t0;
    nReset = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    checks++; if (TxD !== 1'b1) $display("FAIL reset_txd: got %b expected 1", TxD); else passes++;
    checks++; if ({WriteOK, ReadOK} !== 2'b00) $display("FAIL reset_oks: got %b expected 00", {WriteOK, ReadOK}); else passes++;
    checks++; if (DataReadBus !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", DataReadBus); else passes++;
    @(negedge Clock); nReset = 1'b1;
    r0 = rd_ok_cnt; t0 = txd_low_cnt;
    bus_read(BASE + 32'h4, rd, ok);
    checks++; if (ok !== 1'b1) $display("FAIL reset_status_ack: got %b expected 1", ok); else passes++;
    checks++; if (rd !== 32'h0000_0002) $display("FAIL reset_status: got %h expected 00000002", rd); else passes++;
    repeat (5) @(posedge Clock);
    checks++; if (rd_ok_cnt - r0 != 1) $display("FAIL reset_readok_pulses: got %0d expected 1", rd_ok_cnt - r0); else passes++;
    checks++; if (txd_low_cnt != t0) $display("FAIL reset_txd_idle: got %0d low samples expected 0", txd_low_cnt - t0); else passes++;
  endtask

  task automatic test_frame();
    logic [31:0] rd, rd_mid; bit ok, ok2; int lat;
    logic [40:0] samp; logic [3:0] got, want;
    bus_write(BASE + 32'h8, 32'd4, ok);
    @(negedge Clock);
    AddressBus = BASE; DataWriteBus = 32'h55; WriteAssert = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge Clock); #1;
      if (WriteOK === 1'b1) ok = 1'b1;
    end
    WriteAssert = 1'b0;
    lat = 0;
    while (TxD === 1'b1 && lat < 20) begin
      @(negedge Clock); lat++;
    end
    checks++; if (lat != 3) $display("FAIL frame_start_latency: got %0d expected 3", lat); else passes++;
    rd_mid = 32'h0; ok2 = 1'b0;
    fork
      for (int k = 0; k < 41; k++) begin
        samp[k] = TxD;
        @(negedge Clock);
      end
      begin
        repeat (6) @(negedge Clock);
        bus_read(BASE + 32'h4, rd_mid, ok2);
      end
    join
    checks++; if (rd_mid !== 32'h0000_0006) $display("FAIL frame_status_busy: got %h expected 00000006", rd_mid); else passes++;
    for (int b = 0; b < 10; b++) begin
      got = samp[b*4 +: 4];
      for (int j = 0; j < 4; j++) want[j] = exp_txd(8'h55, 4, b*4 + j);
      checks++;
      if (got !== want) $display("FAIL frame_bit%0d: got %b expected %b", b, got, want); else passes++;
    end
    checks++; if (samp[40] !== 1'b1) $display("FAIL frame_idle_after: got %b expected 1", samp[40]); else passes++;
    bus_read(BASE + 32'h4, rd, ok);
    checks++; if (rd !== 32'h0000_0002) $display("FAIL frame_status_done: got %h expected 00000002", rd); else passes++;
  endtask

  task automatic test_both_asserts();
    logic [31:0] rd; bit ok; int w0, r0;
    w0 = wr_ok_cnt; r0 = rd_ok_cnt;
    @(negedge Clock);
    AddressBus = BASE + 32'h8; DataWriteBus = 32'd3; WriteAssert = 1'b1; ReadAssert = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge Clock); #1;
      if (WriteOK === 1'b1) ok = 1'b1;
    end
    WriteAssert = 1'b0; ReadAssert = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    checks++; if (wr_ok_cnt - w0 != 1) $display("FAIL both_writeok: got %0d expected 1", wr_ok_cnt - w0); else passes++;
    checks++; if (rd_ok_cnt - r0 != 0) $display("FAIL both_readok: got %0d expected 0", rd_ok_cnt - r0); else passes++;
    bus_read(BASE + 32'h8, rd, ok);
    checks++; if (rd !== 32'd3) $display("FAIL both_divisor: got %h expected 00000003", rd); else passes++;
  endtask

  task automatic test_registers();
    logic [31:0] rd; bit ok;
    bus_read(BASE, rd, ok);
    checks++; if (ok !== 1'b1 || rd !== 32'h0) $display("FAIL reg_txdata_read: got ok=%b %h expected ok=1 0", ok, rd); else passes++;
    bus_read(BASE + 32'hC, rd, ok);
    checks++; if (ok !== 1'b1 || rd !== 32'h0) $display("FAIL reg_reserved_read: got ok=%b %h expected ok=1 0", ok, rd); else passes++;
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF, ok);
    checks++; if (ok !== 1'b1) $display("FAIL reg_reserved_write_ack: got %b expected 1", ok); else passes++;
    bus_write(BASE + 32'h4, 32'hFFFF_FFF7, ok);
    bus_read(BASE + 32'h4, rd, ok);
    checks++; if (rd !== 32'h0000_0002) $display("FAIL reg_status_ro: got %h expected 00000002", rd); else passes++;
    bus_read(BASE + 32'h8, rd, ok);
    checks++; if (rd !== 32'd3) $display("FAIL reg_divisor_kept: got %h expected 00000003", rd); else passes++;
    bus_write(BASE + 32'h8, 32'hABCD_1234, ok);
    bus_read(BASE + 32'h8, rd, ok);
    checks++; if (rd !== 32'h0000_1234) $display("FAIL reg_divisor_width: got %h expected 00001234", rd); else passes++;
  endtask

  task automatic test_held_write();
    bit ok; int w0;
    logic [59:0] samp, want;
    bus_write(BASE + 32'h8, 32'd2, ok);
    w0 = wr_ok_cnt;
    fork
      begin
        @(negedge Clock);
        AddressBus = BASE; DataWriteBus = 32'hA5; WriteAssert = 1'b1;
        repeat (6) @(posedge Clock);
        @(negedge Clock);
        WriteAssert = 1'b0;
      end
      begin
        @(negedge Clock);
        for (int k = 0; k < 60; k++) begin
          samp[k] = TxD;
          @(negedge Clock);
        end
      end
    join
    for (int k = 0; k < 60; k++) want[k] = exp_txd(8'hA5, 2, k - 3);
    checks++; if (wr_ok_cnt - w0 != 1) $display("FAIL held_writeok: got %0d expected 1", wr_ok_cnt - w0); else passes++;
    checks++; if (samp !== want) $display("FAIL held_frame: got %h expected %h", samp, want); else passes++;
  endtask

  task automatic test_out_of_window();
    logic [31:0] rd; bit ok; int w0, r0, l0, t0;
    w0 = wr_ok_cnt; r0 = rd_ok_cnt; l0 = leak_cnt; t0 = txd_low_cnt;
    @(negedge Clock);
    AddressBus = BASE + 32'h10; DataWriteBus = 32'h5A; WriteAssert = 1'b1;
    repeat (20) @(posedge Clock);
    @(negedge Clock);
    WriteAssert = 1'b0;
    AddressBus = BASE + 32'h18; DataWriteBus = 32'd9; ReadAssert = 1'b1;
    repeat (20) @(posedge Clock);
    @(negedge Clock);
    ReadAssert = 1'b0;
    AddressBus = BASE + 32'h18; WriteAssert = 1'b1;
    repeat (20) @(posedge Clock);
    @(negedge Clock);
    WriteAssert = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    checks++; if (wr_ok_cnt - w0 != 0) $display("FAIL oow_writeok: got %0d expected 0", wr_ok_cnt - w0); else passes++;
    checks++; if (rd_ok_cnt - r0 != 0) $display("FAIL oow_readok: got %0d expected 0", rd_ok_cnt - r0); else passes++;
    checks++; if (leak_cnt != l0) $display("FAIL oow_rdata: got %0d nonzero samples expected 0", leak_cnt - l0); else passes++;
    checks++; if (txd_low_cnt != t0) $display("FAIL oow_txd: got %0d low samples expected 0", txd_low_cnt - t0); else passes++;
    bus_read(BASE + 32'h4, rd, ok);
    checks++; if (rd !== 32'h0000_0002) $display("FAIL oow_status: got %h expected 00000002", rd); else passes++;
    bus_read(BASE + 32'h8, rd, ok);
    checks++; if (rd !== 32'd2) $display("FAIL oow_divisor: got %h expected 00000002", rd); else passes++;
  endtask

  task automatic test_overflow();
    logic [31:0] rd; bit ok; int acks;
    bus_write(BASE + 32'h8, 32'd1000, ok);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      bus_write(BASE, 32'h11 + i, ok);
      if (ok) acks++;
    end
    checks++; if (acks != 6) $display("FAIL ovf_acks: got %0d expected 6", acks); else passes++;
    bus_read(BASE + 32'h4, rd, ok);
    checks++; if (rd !== 32'h0000_040D) $display("FAIL ovf_status: got %h expected 0000040d", rd); else passes++;
    bus_write(BASE + 32'h4, 32'h8, ok);
    bus_read(BASE + 32'h4, rd, ok);
    checks++; if (rd !== 32'h0000_0405) $display("FAIL ovf_clear: got %h expected 00000405", rd); else passes++;
    @(negedge Clock); nReset = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock); nReset = 1'b1;
    bus_read(BASE + 32'h8, rd, ok);
    checks++; if (rd !== 32'd868) $display("FAIL ovf_reset_divisor: got %h expected 00000364", rd); else passes++;
    bus_read(BASE + 32'h4, rd, ok);
    checks++; if (rd !== 32'h0000_0002) $display("FAIL ovf_reset_status: got %h expected 00000002", rd); else passes++;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd; bit ok; int n, t0;
    bus_write(BASE + 32'h8, 32'd4, ok);
    bus_write(BASE, 32'h03, ok);
    bus_write(BASE, 32'hF0, ok);
    n = 0;
    while (TxD !== 1'b1 && n < 50) begin
      @(negedge Clock); n++;
    end
    checks++; if (n >= 50) $display("FAIL mid_bit0_wait: got timeout expected TxD rise"); else passes++;
    repeat (10) @(negedge Clock);
    checks++; if (TxD !== 1'b0) $display("FAIL mid_bit2_level: got %b expected 0", TxD); else passes++;
    nReset = 1'b0;
    #1;
    checks++; if (TxD !== 1'b1) $display("FAIL mid_reset_txd: got %b expected 1", TxD); else passes++;
    checks++; if ({WriteOK, ReadOK} !== 2'b00) $display("FAIL mid_reset_oks: got %b expected 00", {WriteOK, ReadOK}); else passes++;
    repeat (2) @(posedge Clock);
    @(negedge Clock); nReset = 1'b1;
    bus_read(BASE + 32'h4, rd, ok);
    checks++; if (rd !== 32'h0000_0002) $display("FAIL mid_status: got %h expected 00000002", rd); else passes++;
    t0 = txd_low_cnt;
    repeat (100) @(negedge Clock);
    checks++; if (txd_low_cnt != t0) $display("FAIL mid_no_frames: got %0d low samples expected 0", txd_low_cnt - t0); else passes++;
    checks++; if (leak_cnt != 0) $display("FAIL rdata_outside_readok: got %0d samples expected 0", leak_cnt); else passes++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_both_asserts();
    test_registers();
    test_held_write();
    test_out_of_window();
    test_overflow();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
